// File: rtl/i2s_multi_mic_receiver.sv
`default_nettype none
// ============================================================================
// Module   : i2s_multi_mic_receiver
// Purpose  : I2S master receiver for one or more INMP441-class microphone
//            pairs sharing one SCK/WS. Generates SCK/WS from clk, shifts in
//            n_lines SD inputs (left + right slot each) and presents each
//            completed frame as one packed word on a valid/ready handshake.
// Ports    : clk, rst_n     - system clock, synchronous active-low reset
//            sck, ws        - registered I2S bit clock / word select (0=left)
//            sd             - serial data, one bit per line
//            out_data       - slot (2*c+s) at [(2*c+s)*w_sample +: w_sample]
//            out_valid      - frame available
//            out_ready      - consumer accepts the frame
//            overrun        - sticky, an unaccepted frame was overwritten
//            peak           - unsigned per-slot peak magnitude (out_data packing)
//            peak_clr       - restarts peak tracking
// Options  : I2S_MIC_PEAK_EN - enables peak tracking; otherwise peak is 0
// Revision : 1.0 - initial release
// ============================================================================
module i2s_multi_mic_receiver #(
  parameter int n_lines  = 1,
  parameter int w_sample = 24,
  parameter int sck_half = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  output logic                            sck,
  output logic                            ws,
  input  logic [n_lines-1:0]              sd,
  output logic [2*n_lines*w_sample-1:0]   out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            overrun,
  output logic [2*n_lines*w_sample-1:0]   peak,
  input  logic                            peak_clr
);

  localparam int                c_hc_w       = (sck_half > 2) ? $clog2(sck_half) : 1;
  localparam int                c_dw         = 2 * n_lines * w_sample;
  localparam logic [c_hc_w-1:0] c_hc_last    = c_hc_w'(sck_half - 1);
  localparam logic [4:0]        c_last_bit   = 5'(w_sample);
  localparam logic [5:0]        c_left_done  = 6'(w_sample);
  localparam logic [5:0]        c_right_done = 6'(32 + w_sample);

  logic [c_hc_w-1:0] r_hc;
  logic              r_sck;
  logic              r_ws;
  logic [5:0]        r_bit_cnt;
  logic              r_frame_done;
  logic [c_dw-1:0]   r_out_data;
  logic              r_out_valid;
  logic              r_overrun;

  logic              w_edge;
  logic              w_rise;
  logic              w_fall;
  logic              w_shift;
  logic              w_left_done;
  logic              w_right_done;
  logic [5:0]        w_bit_cnt_next;
  logic [c_dw-1:0]   w_frame;

  // --------------------------------------------------------------------------
  // Bit clock generation
  // --------------------------------------------------------------------------
  assign w_edge         = (r_hc == c_hc_last);
  assign w_rise         = w_edge && !r_sck;
  assign w_fall         = w_edge && r_sck;
  assign w_bit_cnt_next = r_bit_cnt + 6'd1;

  // bit 0 of each slot is the I2S delay bit; bits 1..w_sample carry data
  assign w_shift      = w_rise && (r_bit_cnt[4:0] != 5'd0) && (r_bit_cnt[4:0] <= c_last_bit);
  assign w_left_done  = w_rise && (r_bit_cnt == c_left_done);
  assign w_right_done = w_rise && (r_bit_cnt == c_right_done);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hc         <= '0;
      r_sck        <= 1'b0;
      r_ws         <= 1'b0;
      r_bit_cnt    <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_hc         <= w_edge ? '0 : r_hc + c_hc_w'(1);
      r_frame_done <= w_right_done;
      if (w_edge) begin
        r_sck <= ~r_sck;
      end
      // WS follows the slot bit of the count, so it changes on the falling
      // edge that starts the delay bit of a slot
      if (w_fall) begin
        r_bit_cnt <= w_bit_cnt_next;
        r_ws      <= w_bit_cnt_next[5];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Per-line shift and hold registers
  // --------------------------------------------------------------------------
  for (genvar c = 0; c < n_lines; c++) begin : g_line
    logic [w_sample-1:0] r_left_sr;
    logic [w_sample-1:0] r_right_sr;
    logic [w_sample-1:0] r_left_hold;
    logic [w_sample-1:0] w_left_next;
    logic [w_sample-1:0] w_right_next;

    assign w_left_next  = w_sample'({r_left_sr, sd[c]});
    assign w_right_next = w_sample'({r_right_sr, sd[c]});

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_left_sr   <= '0;
        r_right_sr  <= '0;
        r_left_hold <= '0;
      end else begin
        if (w_shift && !r_bit_cnt[5]) begin
          r_left_sr <= w_left_next;
        end
        if (w_shift && r_bit_cnt[5]) begin
          r_right_sr <= w_right_next;
        end
        // capture includes the last bit arriving on this same edge
        if (w_left_done) begin
          r_left_hold <= w_left_next;
        end
      end
    end

    // right shift registers are stable for sck_half cycles after the last
    // bit, so the frame is assembled one cycle after the final rising event
    assign w_frame[(2*c)*w_sample   +: w_sample] = r_left_hold;
    assign w_frame[(2*c+1)*w_sample +: w_sample] = r_right_sr;
  end

  // --------------------------------------------------------------------------
  // Output handshake
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else if (r_frame_done) begin
      r_out_data  <= w_frame;
      r_out_valid <= 1'b1;
      if (r_out_valid && !out_ready) begin
        r_overrun <= 1'b1;
      end
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Peak tracking
  // --------------------------------------------------------------------------
`ifdef I2S_MIC_PEAK_EN
  for (genvar s = 0; s < 2 * n_lines; s++) begin : g_slot
    logic [w_sample-1:0] w_smp;
    logic [w_sample-1:0] w_mag;
    logic [w_sample-1:0] r_peak;

    // the most negative sample negates to itself, which read unsigned is
    // exactly its magnitude
    assign w_smp = w_frame[s*w_sample +: w_sample];
    assign w_mag = w_smp[w_sample-1] ? (~w_smp + w_sample'(1)) : w_smp;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_peak <= '0;
      end else if (r_frame_done) begin
        r_peak <= (peak_clr || (w_mag > r_peak)) ? w_mag : r_peak;
      end else if (peak_clr) begin
        r_peak <= '0;
      end
    end

    assign peak[s*w_sample +: w_sample] = r_peak;
  end
`else
  logic w_unused_peak_clr;
  assign w_unused_peak_clr = peak_clr;
  assign peak              = '0;
`endif

  assign sck       = r_sck;
  assign ws        = r_ws;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: doc/i2s_multi_mic_receiver.md
# i2s_multi_mic_receiver

Parametrised I2S master receiver for one or more INMP441-class microphone pairs sharing one SCK/WS. It generates SCK and WS from the system clock and samples `n_lines` SD inputs, each carrying a left and a right microphone. Each completed frame is presented as one packed word of `2*n_lines` signed samples on a valid/ready handshake. It sits between the GPIO pins and the `mic` consumer in the board top, and generalises the single-microphone receiver.

## Interface
- `n_lines`, 1: number of SD inputs; each carries a left and a right slot.
- `w_sample`, 24: bits captured per slot, MSB first; legal range 1..31.
- `sck_half`, 8: clk cycles per SCK half-period; minimum 2. At 50 MHz this gives SCK 3.125 MHz and WS 48.8 kHz.

- `clk` input 1: system clock. Single clock domain.
- `rst_n` input 1: reset, synchronous, active-low.
- `sck` output 1: I2S bit clock; registered.
- `ws` output 1: word select; 0 = left slot, 1 = right slot; registered.
- `sd` input `n_lines`: serial data, one bit per line.
- `out_data` output `2*n_lines*w_sample`: slot `(2*c+s)` occupies `[(2*c+s)*w_sample +: w_sample]`, where `c` is the line and `s` is 0 for left, 1 for right. Two's complement.
- `out_valid` output 1: frame available.
- `out_ready` input 1: consumer accepts the frame.
- `overrun` output 1: sticky; set when an unaccepted frame is overwritten.
- `peak` output `2*n_lines*w_sample`: unsigned per-slot peak magnitude, same packing as `out_data`.
- `peak_clr` input 1: restarts peak tracking.

## Operation
- Half-period counter `hc` runs 0..`sck_half`-1. When `hc == sck_half-1`, `sck` toggles.
- Rising event: `sck` toggles 0→1.
  - `k = bit_cnt[4:0]`.
  - `k == 0` is the I2S delay bit and is ignored.
  - For `1 <= k <= w_sample`, `sd[c]` is shifted into the slot shift register selected by `bit_cnt[5]`.
  - `sd` is sampled directly; it is stable for `sck_half` clk cycles before the event.
- Falling event: `sck` toggles 1→0. `bit_cnt` increments modulo 64 and `ws` <= new `bit_cnt[5]`. WS therefore changes on the falling edge that starts bit 0 of a slot.
- Left slot completes at the rising event with `bit_cnt == w_sample`: all left shift registers copy to left hold registers.
- Right slot completes at the rising event with `bit_cnt == 32 + w_sample`: this is the frame-complete event.
- Frame-complete loads `out_data` from the left hold registers and the right shift registers, and sets `out_valid`.
- Handshake:
  - `out_valid && out_ready` clears `out_valid`, unless frame-complete occurs in the same cycle. In that case the new data loads, `out_valid` stays 1 and `overrun` is unchanged.
  - Frame-complete while `out_valid && !out_ready`: data is overwritten, `out_valid` stays 1, `overrun` is set to 1.
  - `overrun` clears only on reset.
  - `out_data` is stable whenever `out_valid` is high and no frame-complete occurs.

## Timing
- Reset values: `sck` 0, `ws` 0, `hc` 0, `bit_cnt` 0, shift and hold registers 0, `out_data` 0, `out_valid` 0, `overrun` 0, `peak` 0.
- Reset mid-frame: all state returns to reset values on the next clk edge, and the partial frame is discarded.
- First rising event: `sck_half` cycles after `rst_n` deasserts; this is the `k=0` delay bit.
- SCK period: `2*sck_half` clk cycles. Frame period: `128*sck_half` clk cycles.
- `out_valid` rises 1 clk cycle after the frame-complete event.
- First frame: `out_valid` rises `(2*(32+w_sample)+1)*sck_half + 1` clk cycles after `rst_n` deasserts.

## Configuration
- Macro `I2S_MIC_PEAK_EN`.
- Defined:
  - On frame-complete, each `peak` slot becomes max(`peak`, |sample|).
  - |−2^(w_sample−1)| = 2^(w_sample−1), which fits unsigned.
  - `peak_clr` zeroes `peak` 1 cycle later.
  - `peak_clr` in the same cycle as frame-complete loads the new frame's magnitudes.
- Undefined: `peak` is tied to 0 and `peak_clr` is ignored. All other behaviour is identical.

## Test plan
- Reset, `rst_n`=1, `n_lines`=1, `sck_half`=2:
  - `sck` toggles every 2 clk cycles.
  - `ws` rises at the falling edge starting bit 32.
  - `out_valid` rises 1 cycle after rising event with `bit_cnt`=56.
- Model drives left 24'h800001, right 24'h7FFFFF (MSB one SCK after WS edge), `out_ready`=1:
  - `out_data` = {24'h7FFFFF, 24'h800001}.
  - `out_valid` is high for 1 cycle.
- `n_lines`=2, distinct patterns 24'h123456, 24'hABCDEF, 24'h000001, 24'hFFFFFF on the four slots → each appears at its packed offset.
- `out_ready`=0 for two frames → second frame overwrites the first, `overrun`=1 and stays 1. Accept in the frame-complete cycle → `out_valid` stays 1.
- `rst_n` low at `bit_cnt`=40 → all outputs reset next cycle, and the partial frame is never presented.
- With `I2S_MIC_PEAK_EN`:
  - Samples −5, 3, −2^23 → `peak` = 5, 5, 24'h800000.
  - `peak_clr` → 0.
  - Without the macro, `peak` stays 0.
